// File: rtl/systolic_matmul_engine.sv
// -----------------------------------------------------------------------------
// systolic_matmul_engine
//
// Purpose
//   N x N matrix multiply, C = A x B, on an output-stationary systolic grid.
//   An accepted operand set is loaded into per-row (A) and per-column (B) skew
//   queues. The queues feed the left and top edges of the PE grid with zero
//   bubbles outside the valid window. Operands then hop one PE per cycle,
//   A to the right and B downward. Each PE accumulates its own C element.
//   The result is held in DONE until the downstream stage takes it. A new job
//   can be accepted on the same edge that the result is taken.
//
// Ports
//   i_clk     clock, rising edge
//   i_arst    asynchronous reset, active-high
//   i_a       matrix A, i_a[r][k] = row r, column k
//   i_b       matrix B, i_b[k][c] = row k, column c
//   i_signed  1 = two's-complement operands, sampled when a job is accepted
//   i_valid   operand set valid
//   o_ready   engine can accept an operand set
//   o_c       result matrix, o_c[r][c] (meaningful while o_valid = 1)
//   o_valid   o_c holds a complete result
//   i_ready   downstream accepts the result
// -----------------------------------------------------------------------------
module systolic_matmul_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                            i_clk,
    input  logic                            i_arst,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0] i_b,
    input  logic                            i_signed,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic [N-1:0][N-1:0][ACC_W-1:0]  o_c,
    output logic                            o_valid,
    input  logic                            i_ready
);

    // Row r of A / column c of B needs r (or c) leading bubbles plus N
    // operands, so the longest queue holds 2N-1 slots.
    localparam int SKEW_LEN = 2 * N - 1;
    localparam int CNT_W    = $clog2(3 * N);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(3 * N - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic [CNT_W-1:0]                       r_step;
    logic                                   r_signed;
    logic                                   w_accept;
    logic                                   w_run;

    // Skew queues: slot 0 is presented to the grid edge this cycle.
    logic [N-1:0][SKEW_LEN-1:0][DATA_W-1:0] r_a_skew;
    logic [N-1:0][SKEW_LEN-1:0][DATA_W-1:0] r_b_skew;
    logic [N-1:0][SKEW_LEN-1:0][DATA_W-1:0] w_a_load;
    logic [N-1:0][SKEW_LEN-1:0][DATA_W-1:0] w_b_load;

    // Inter-PE operand registers. The last column never forwards A and the
    // last row never forwards B, so those registers do not exist.
    logic [N-1:0][N-2:0][DATA_W-1:0]        r_a_pipe;
    logic [N-2:0][N-1:0][DATA_W-1:0]        r_b_pipe;

    // Operand seen by PE(r,c) this cycle.
    logic [N-1:0][N-1:0][DATA_W-1:0]        w_a_in;
    logic [N-1:0][N-1:0][DATA_W-1:0]        w_b_in;
    logic [N-1:0][DATA_W-1:0]               w_b_top;

    logic [N-1:0][N-1:0][ACC_W-1:0]         w_prod;
    logic [N-1:0][N-1:0][ACC_W-1:0]         r_acc;

    // Sign- or zero-extend an operand to accumulator width.
    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v,
                                             input logic              s);
        return {{(ACC_W - DATA_W){s & v[DATA_W-1]}}, v};
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of the order the blocks execute.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_step <= CNT_W'(1);
            end else if (w_run) begin
                r_step <= (r_step == LAST_STEP) ? '0 : r_step + CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (r_step == LAST_STEP) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                // Ready follows the downstream so a result hand-off and the
                // next accept can share one edge.
                o_ready = i_ready;
                if (i_ready) begin
                    w_state_nxt = i_valid ? S_RUN : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = i_valid & o_ready;

    // -------------------------------------------------------------------------
    // Skew-queue load image: A[r][k] sits at slot r+k of row r's queue,
    // B[k][c] at slot c+k of column c's queue, everything else is a bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        w_a_load = '0;
        w_b_load = '0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                w_a_load[r][r + k] = i_a[r][k];
                w_b_load[r][r + k] = i_b[k][r];  // r indexes the B column here
            end
        end
    end

    // -------------------------------------------------------------------------
    // Grid operand routing and PE products
    // -------------------------------------------------------------------------
    always_comb begin
        w_a_in  = '0;
        w_b_top = '0;
        for (int c = 0; c < N; c++) begin
            w_b_top[c] = r_b_skew[c][0];
        end
        for (int r = 0; r < N; r++) begin
            w_a_in[r] = {r_a_pipe[r], r_a_skew[r][0]};
        end
        w_b_in = {r_b_pipe, w_b_top};
    end

    always_comb begin
        w_prod = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                w_prod[r][c] = ext(w_a_in[r][c], r_signed) * ext(w_b_in[r][c], r_signed);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the accumulator and operand arrays are flops, not RAM, and are
    // reset so o_c reads zero out of reset and an aborted job leaves nothing.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_a_skew <= '0;
            r_b_skew <= '0;
            r_a_pipe <= '0;
            r_b_pipe <= '0;
            r_acc    <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_a_skew <= w_a_load;
            r_b_skew <= w_b_load;
            r_a_pipe <= '0;
            r_b_pipe <= '0;
            r_acc    <= '0;
            r_signed <= i_signed;
        end else if (w_run) begin
            for (int i = 0; i < N; i++) begin
                r_a_skew[i] <= {{DATA_W{1'b0}}, r_a_skew[i][SKEW_LEN-1:1]};
                r_b_skew[i] <= {{DATA_W{1'b0}}, r_b_skew[i][SKEW_LEN-1:1]};
                r_a_pipe[i] <= w_a_in[i][N-2:0];
            end
            r_b_pipe <= w_b_in[N-2:0];
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_acc[r][c] <= r_acc[r][c] + w_prod[r][c];
                end
            end
        end
    end

    assign o_c = r_acc;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// -----------------------------------------------------------------------------
// tb_systolic_matmul_engine
//
// Purpose
//   Scoreboard bench for systolic_matmul_engine. Three instances are built:
//   the default N=4/ACC_W=32 engine, an N=4/ACC_W=16 engine for accumulator
//   wrap, and an N=2 engine for small-grid latency. Stimulus pushes the
//   hand-computed result of each accepted job into a per-instance queue; a
//   monitor per instance pops and compares whenever a result is handed off.
// -----------------------------------------------------------------------------
module tb_systolic_matmul_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    typedef logic [N-1:0][N-1:0][DW-1:0] op4_t;
    typedef logic [N-1:0][N-1:0][AW-1:0] res4_t;
    typedef logic [N-1:0][N-1:0][15:0]   res16_t;
    typedef logic [1:0][1:0][DW-1:0]     op2_t;
    typedef logic [1:0][1:0][AW-1:0]     res2_t;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance
    op4_t  a, b;
    logic  sgn, vin, rdy_in, rdy_out, vout;
    res4_t c;

    // Wrap instance
    op4_t   w_a, w_b;
    logic   w_sgn, w_vin, w_rdy_in, w_rdy_out, w_vout;
    res16_t w_c;

    // N=2 instance
    op2_t  n2_a, n2_b;
    logic  n2_sgn, n2_vin, n2_rdy_in, n2_rdy_out, n2_vout;
    res2_t n2_c;

    res4_t  sb_q[$];
    res16_t sbw_q[$];
    res2_t  sb2_q[$];

    systolic_matmul_engine #(.N(N), .DATA_W(DW), .ACC_W(AW)) u_dut (
        .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_signed(sgn),
        .i_valid(vin), .o_ready(rdy_out), .o_c(c), .o_valid(vout), .i_ready(rdy_in)
    );

    systolic_matmul_engine #(.N(N), .DATA_W(DW), .ACC_W(16)) u_dut_wrap (
        .i_clk(clk), .i_arst(arst), .i_a(w_a), .i_b(w_b), .i_signed(w_sgn),
        .i_valid(w_vin), .o_ready(w_rdy_out), .o_c(w_c), .o_valid(w_vout), .i_ready(w_rdy_in)
    );

    systolic_matmul_engine #(.N(2), .DATA_W(DW), .ACC_W(AW)) u_dut_n2 (
        .i_clk(clk), .i_arst(arst), .i_a(n2_a), .i_b(n2_b), .i_signed(n2_sgn),
        .i_valid(n2_vin), .o_ready(n2_rdy_out), .o_c(n2_c), .o_valid(n2_vout), .i_ready(n2_rdy_in)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: result presented with no job outstanding", name);
    endtask

    // ---------------------------------------------------------------- monitors
    always @(negedge clk) begin
        if (!arst && vout && rdy_in) begin
            if (sb_q.size() == 0) unexpected("main_result");
            else check("main_result", 512'(c), 512'(sb_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!arst && w_vout && w_rdy_in) begin
            if (sbw_q.size() == 0) unexpected("wrap_result");
            else check("wrap_result", 512'(w_c), 512'(sbw_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!arst && n2_vout && n2_rdy_in) begin
            if (sb2_q.size() == 0) unexpected("n2_result");
            else check("n2_result", 512'(n2_c), 512'(sb2_q.pop_front()));
        end
    end

    // ------------------------------------------------------------- operands
    function automatic op4_t diag(input logic [7:0] v);
        op4_t m = '0;
        for (int i = 0; i < N; i++) m[i][i] = v;
        return m;
    endfunction

    function automatic op4_t fill_op(input logic [7:0] v);
        op4_t m;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) m[r][k] = v;
        return m;
    endfunction

    // B[k][c] = 4k + c + 1
    function automatic op4_t b_pattern();
        op4_t m;
        for (int k = 0; k < N; k++)
            for (int cc = 0; cc < N; cc++) m[k][cc] = 8'(4 * k + cc + 1);
        return m;
    endfunction

    function automatic res4_t fill_res(input logic [31:0] v);
        res4_t m;
        for (int r = 0; r < N; r++)
            for (int cc = 0; cc < N; cc++) m[r][cc] = v;
        return m;
    endfunction

    function automatic res16_t fill_res16(input logic [15:0] v);
        res16_t m;
        for (int r = 0; r < N; r++)
            for (int cc = 0; cc < N; cc++) m[r][cc] = v;
        return m;
    endfunction

    // s * B pattern, i.e. the product of (s * I) with b_pattern()
    function automatic res4_t scaled_pattern(input int s);
        res4_t m;
        for (int r = 0; r < N; r++)
            for (int cc = 0; cc < N; cc++) m[r][cc] = 32'(s * (4 * r + cc + 1));
        return m;
    endfunction

    // Drives a job just after a rising edge, waits for o_ready, pushes the
    // expected result at the accepting edge and optionally measures latency.
    task automatic issue(input op4_t ta, input op4_t tb_, input logic ts,
                         input res4_t exp, input int exp_lat, input bit release_ready);
        int wait_n;
        int lat;
        @(posedge clk);
        #1;
        a = ta; b = tb_; sgn = ts; vin = 1'b1;
        if (release_ready) rdy_in = 1'b1;
        wait_n = 0;
        @(negedge clk);
        while (!rdy_out && wait_n < 100) begin
            wait_n++;
            @(negedge clk);
        end
        check("accept_ready", 512'(rdy_out), 512'(1));
        if (release_ready) check("same_edge_accept_wait", 512'(wait_n), 512'(0));
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        // Scramble inputs after accept: the engine must use the latched job.
        vin = 1'b0; a = ~ta; b = ~tb_; sgn = ~ts;
        if (exp_lat > 0) begin
            lat = 0;
            do begin
                lat++;
                @(negedge clk);
                if (lat == 1) check("c_cleared_after_accept", 512'(c), 512'(0));
            end while (!vout && lat < 60);
            check("latency", 512'(lat), 512'(exp_lat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int    n_valid;
        int    wait_n;
        int    lat;
        res2_t exp2;

        arst = 1'b1;
        a = '0; b = '0; sgn = 1'b0; vin = 1'b0; rdy_in = 1'b1;
        w_a = '0; w_b = '0; w_sgn = 1'b0; w_vin = 1'b0; w_rdy_in = 1'b1;
        n2_a = '0; n2_b = '0; n2_sgn = 1'b0; n2_vin = 1'b0; n2_rdy_in = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_valid", 512'(vout), 512'(0));
        check("reset_ready", 512'(rdy_out), 512'(1));
        check("reset_c", 512'(c), 512'(0));
        @(posedge clk);
        #1 arst = 1'b0;

        // Identity times pattern, unsigned: C == B, first valid in cycle 11
        issue(diag(8'd1), b_pattern(), 1'b0, scaled_pattern(1), 11, 1'b0);
        // Unsigned max: 4 * 255 * 255
        issue(fill_op(8'hFF), fill_op(8'hFF), 1'b0, fill_res(32'd260100), 11, 1'b0);
        // Signed: 4 * (-128) * 127
        issue(fill_op(8'h80), fill_op(8'h7F), 1'b1, fill_res(32'hFFFF0200), 11, 1'b0);
        // Signed -I times pattern: C == -B
        issue(diag(8'hFF), b_pattern(), 1'b1, scaled_pattern(-1), 11, 1'b0);

        // Backpressure: hold the result, then release with a same-edge accept
        @(posedge clk);
        #1 rdy_in = 1'b0;
        issue(fill_op(8'hFF), fill_op(8'hFF), 1'b0, fill_res(32'd260100), 11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid_held", 512'(vout), 512'(1));
            check("bp_ready_low", 512'(rdy_out), 512'(0));
            check("bp_c_held", 512'(c), 512'(fill_res(32'd260100)));
        end
        issue(diag(8'd2), b_pattern(), 1'b0, scaled_pattern(2), 11, 1'b1);

        // Reset during RUN step 5 aborts the job
        issue(diag(8'd1), b_pattern(), 1'b0, scaled_pattern(1), 0, 1'b0);
        repeat (4) @(posedge clk);
        #1 arst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("abort_valid", 512'(vout), 512'(0));
        check("abort_ready", 512'(rdy_out), 512'(1));
        check("abort_c", 512'(c), 512'(0));
        @(posedge clk);
        #1 arst = 1'b0;
        n_valid = 0;
        repeat (3 * N + 2) begin
            @(negedge clk);
            if (vout) n_valid++;
        end
        check("abort_no_result", 512'(n_valid), 512'(0));
        issue(diag(8'd1), b_pattern(), 1'b0, scaled_pattern(1), 11, 1'b0);

        // Wrap: ACC_W = 16, 260100 mod 65536 = 63492
        @(posedge clk);
        #1;
        w_a = fill_op(8'hFF); w_b = fill_op(8'hFF); w_sgn = 1'b0; w_vin = 1'b1;
        @(negedge clk);
        check("wrap_ready", 512'(w_rdy_out), 512'(1));
        @(posedge clk);
        sbw_q.push_back(fill_res16(16'd63492));
        #1 w_vin = 1'b0;

        // N=2 signed: A = [[-1,2],[3,-4]], B = [[5,-6],[7,8]]
        //   C = [[9,22],[-13,-50]], first valid in cycle 5
        n2_a[0][0] = 8'hFF; n2_a[0][1] = 8'd2; n2_a[1][0] = 8'd3; n2_a[1][1] = 8'hFC;
        n2_b[0][0] = 8'd5;  n2_b[0][1] = 8'hFA; n2_b[1][0] = 8'd7; n2_b[1][1] = 8'd8;
        exp2[0][0] = 32'd9;
        exp2[0][1] = 32'd22;
        exp2[1][0] = 32'hFFFF_FFF3;
        exp2[1][1] = 32'hFFFF_FFCE;
        n2_sgn = 1'b1; n2_vin = 1'b1;
        @(negedge clk);
        check("n2_ready", 512'(n2_rdy_out), 512'(1));
        @(posedge clk);
        sb2_q.push_back(exp2);
        #1 n2_vin = 1'b0;
        lat = 0;
        do begin
            lat++;
            @(negedge clk);
        end while (!n2_vout && lat < 60);
        check("n2_latency", 512'(lat), 512'(5));

        // Drain: every pushed job must have produced exactly one result
        wait_n = 0;
        while ((sb_q.size() + sbw_q.size() + sb2_q.size()) != 0 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        check("main_pending", 512'(sb_q.size()), 512'(0));
        check("wrap_pending", 512'(sbw_q.size()), 512'(0));
        check("n2_pending", 512'(sb2_q.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
